// File: rtl/layer1_weight_sequencer_pkg.sv
`default_nettype none
// layer1_weight_sequencer_pkg: shared state encoding and sizing helper.
// Revision: 1.0
package layer1_weight_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_SCAN   = 3'd3,
    ST_DRAIN  = 3'd4
  } seq_state_t;

  // A single-lane row still needs a 1-bit counter to keep the ports legal.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer1_weight_sequencer_row_packer.sv
`default_nettype none
// layer1_weight_sequencer_row_packer: gathers serial weight words into one storage row.
// Revision: 1.0
module layer1_weight_sequencer_row_packer
  import layer1_weight_sequencer_pkg::*;
#(
  parameter int RELU_NODES        = 16,
  parameter int LAYER_1_BIT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   accept,
  input  logic [LAYER_1_BIT_WIDTH-1:0]           word_in,
  output logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0] pack_row,
  output logic                                   row_full
);

  localparam int LANE_W = lane_width(RELU_NODES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RELU_NODES - 1);

  logic [LANE_W-1:0] lane_cnt;

  // High on the handshake that fills the final lane.
  assign row_full = accept && (lane_cnt == LAST_LANE);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt <= '0;
      pack_row <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
    end else if (accept) begin
      for (int l = 0; l < RELU_NODES; l++) begin
        if (lane_cnt == LANE_W'(l)) begin
          pack_row[l*LAYER_1_BIT_WIDTH +: LAYER_1_BIT_WIDTH] <= word_in;
        end
      end
      lane_cnt <= row_full ? '0 : lane_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/layer1_weight_sequencer.sv
`default_nettype none
// layer1_weight_sequencer: loads weight rows into Layer1WeightStorage and scans them out.
// Revision: 1.0
module layer1_weight_sequencer
  import layer1_weight_sequencer_pkg::*;
#(
  parameter int RELU_NODES        = 16,
  parameter int LAYER_1_BIT_WIDTH = 8,
  parameter int NUM_ROWS          = 784,
  parameter int SEL_WIDTH         = 10
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    loadStart,
  input  logic                                    scanStart,
  input  logic [LAYER_1_BIT_WIDTH-1:0]            wordIn,
  input  logic                                    wordValid,
  output logic                                    wordReady,
  output logic                                    writeEnable,
  output logic [SEL_WIDTH-1:0]                    NodeSelect,
  output logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0] writeIn,
  input  logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0] readOut,
  output logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0] rowOut,
  output logic [SEL_WIDTH-1:0]                    rowIndex,
  output logic                                    rowValid,
  input  logic                                    rowReady,
  output logic                                    busy,
  output logic                                    loadDone,
  output logic                                    scanDone
);

  localparam logic [SEL_WIDTH-1:0] LAST_ROW = SEL_WIDTH'(NUM_ROWS - 1);

  seq_state_t           state;
  seq_state_t           state_next;
  logic [SEL_WIDTH-1:0] row_cnt;
  logic                 word_accept;
  logic                 row_full;
  logic                 capture;
  logic                 pack_clear;
  logic                 last_row;

  assign word_accept = (state == ST_LOAD) && wordValid;
  assign capture     = (state == ST_SCAN) && (!rowValid || rowReady);
  assign pack_clear  = (state == ST_IDLE) && loadStart;
  assign last_row    = (row_cnt == LAST_ROW);

  layer1_weight_sequencer_row_packer #(
    .RELU_NODES       (RELU_NODES),
    .LAYER_1_BIT_WIDTH(LAYER_1_BIT_WIDTH)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pack_clear),
    .accept  (word_accept),
    .word_in (wordIn),
    .pack_row(writeIn),
    .row_full(row_full)
  );

  // Storage address follows the row counter in every state; it holds the last row through DRAIN.
  assign NodeSelect = row_cnt;

  always_comb begin
    state_next  = state;
    wordReady   = 1'b0;
    writeEnable = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (loadStart)      state_next = ST_LOAD;
        else if (scanStart) state_next = ST_SCAN;
      end
      ST_LOAD: begin
        wordReady = 1'b1;
        if (row_full) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        writeEnable = 1'b1;
        state_next  = last_row ? ST_IDLE : ST_LOAD;
      end
      ST_SCAN: begin
        if (capture && last_row) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rowReady) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      row_cnt  <= '0;
      rowOut   <= '0;
      rowIndex <= '0;
      rowValid <= 1'b0;
      loadDone <= 1'b0;
      scanDone <= 1'b0;
    end else begin
      state    <= state_next;
      loadDone <= 1'b0;
      scanDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (loadStart || scanStart) row_cnt <= '0;
        end
        ST_COMMIT: begin
          if (last_row) begin
            row_cnt  <= '0;
            loadDone <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          if (capture) begin
            rowOut   <= readOut;
            rowIndex <= row_cnt;
            rowValid <= 1'b1;
            if (!last_row) row_cnt <= row_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (rowReady) begin
            rowValid <= 1'b0;
            scanDone <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer1_weight_sequencer.sv
`default_nettype none
// tb_layer1_weight_sequencer: directed load/scan scenarios against a scoreboard model and a storage array.
// Revision: 1.0
module tb_layer1_weight_sequencer;

  localparam int RN = 2;
  localparam int BW = 8;
  localparam int NR = 3;
  localparam int SW = 2;
  localparam int RW = RN * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          loadStart = 1'b0;
  logic          scanStart = 1'b0;
  logic [BW-1:0] wordIn = '0;
  logic          wordValid = 1'b0;
  logic          rowReady = 1'b0;
  logic          wordReady, writeEnable, rowValid, busy, loadDone, scanDone;
  logic [SW-1:0] NodeSelect, rowIndex;
  logic [RW-1:0] writeIn, readOut, rowOut;

  layer1_weight_sequencer #(
    .RELU_NODES(RN), .LAYER_1_BIT_WIDTH(BW), .NUM_ROWS(NR), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .loadStart(loadStart), .scanStart(scanStart),
    .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
    .writeEnable(writeEnable), .NodeSelect(NodeSelect), .writeIn(writeIn),
    .readOut(readOut), .rowOut(rowOut), .rowIndex(rowIndex), .rowValid(rowValid),
    .rowReady(rowReady), .busy(busy), .loadDone(loadDone), .scanDone(scanDone)
  );

  always #5 clk = ~clk;

  // Stand-in for Layer1WeightStorage: synchronous write, combinational read.
  logic [RW-1:0] mem [0:3];
  assign readOut = mem[NodeSelect];
  always @(posedge clk) if (writeEnable) mem[NodeSelect] <= writeIn;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what the storage should contain, and the ordered writes/reads the DUT owes.
  logic [RW-1:0] model_mem [0:NR-1];
  int            wr_idx_q[$];
  logic [RW-1:0] wr_dat_q[$];
  int            rd_idx_q[$];
  logic [RW-1:0] rd_dat_q[$];

  function automatic logic [RW-1:0] model_row(input logic [BW-1:0] w[$], input int r);
    logic [RW-1:0] v = '0;
    for (int l = 0; l < RN; l++) v = v | (RW'(w[r*RN + l]) << (BW * l));
    return v;
  endfunction

  task automatic expect_writes(input logic [BW-1:0] w[$], input int nrows);
    for (int r = 0; r < nrows; r++) begin
      model_mem[r] = model_row(w, r);
      wr_idx_q.push_back(r);
      wr_dat_q.push_back(model_mem[r]);
    end
  endtask

  task automatic expect_scan();
    for (int r = 0; r < NR; r++) begin
      rd_idx_q.push_back(r);
      rd_dat_q.push_back(model_mem[r]);
    end
  endtask

  int            ld_cnt = 0, ld_cyc = 0, sd_cnt = 0, sd_cyc = 0, nv_cnt = 0;
  logic          ld_busy, sd_busy;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_out;
  logic [SW-1:0] prev_idx;

  // Single compare process: every meaningful cycle is checked against the model.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (writeEnable) begin
        check("commit_wordready", wordReady, 1'b0);
        if (wr_idx_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("write_addr", NodeSelect, wr_idx_q.pop_front());
          check("write_data", writeIn, wr_dat_q.pop_front());
        end
      end
      if (prev_stall) begin
        check("stall_valid", rowValid, 1'b1);
        check("stall_rowout", rowOut, prev_out);
        check("stall_rowidx", rowIndex, prev_idx);
      end
      if (rowValid) nv_cnt++;
      if (rowValid && rowReady) begin
        if (rd_idx_q.size() == 0) check("unexpected_row", 1, 0);
        else begin
          check("row_index", rowIndex, rd_idx_q.pop_front());
          check("row_data", rowOut, rd_dat_q.pop_front());
        end
      end
      if (loadDone) begin ld_cnt++; ld_cyc = cyc; ld_busy = busy; end
      if (scanDone) begin sd_cnt++; sd_cyc = cyc; sd_busy = busy; end
      prev_stall = rowValid && !rowReady;
      prev_out   = rowOut;
      prev_idx   = rowIndex;
    end
  end

  int t_start;

  task automatic start(input logic ld, input logic sc);
    loadStart = ld;
    scanStart = sc;
    t_start   = cyc;
    @(posedge clk); #1;
    loadStart = 1'b0;
    scanStart = 1'b0;
  endtask

  task automatic load_words(input logic [BW-1:0] w[$], input bit toggle);
    int  guard = 0;
    bit  hs;
    for (int i = 0; i < w.size();) begin
      wordIn    = w[i];
      wordValid = toggle ? ~wordValid : 1'b1;
      @(negedge clk);
      hs = wordValid && wordReady;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
      if (guard > 200) begin
        check("word_timeout", 1, 0);
        break;
      end
    end
    wordValid = 1'b0;
  endtask

  task automatic wait_load(input int prev);
    for (int i = 0; i < 100 && ld_cnt == prev; i++) @(posedge clk);
    #1;
    check("load_done_count", ld_cnt, prev + 1);
    check("busy_after_load", ld_busy, 1'b0);
  endtask

  task automatic scan(input int stall_n, output logic [RW-1:0] hold_out, output logic [SW-1:0] hold_idx);
    int prev = sd_cnt;
    int stall = 0;
    hold_out = '0;
    hold_idx = '0;
    rowReady = 1'b1;
    start(1'b0, 1'b1);
    for (int i = 0; i < 100 && sd_cnt == prev; i++) begin
      if (rowValid && rowIndex == 1 && stall < stall_n) begin
        rowReady = 1'b0;
        stall++;
        hold_out = rowOut;
        hold_idx = rowIndex;
      end else begin
        rowReady = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("scan_done_count", sd_cnt, prev + 1);
    check("busy_after_scan", sd_busy, 1'b0);
  endtask

  logic [BW-1:0] wa[$], wb[$], wc[$], wd[$];
  logic [RW-1:0] h_out;
  logic [SW-1:0] h_idx;
  int            nv0, sd0;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    wa = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    wc = '{8'h11, 8'h22, 8'h33};
    wd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);         check("rst_wordready", wordReady, 0);
    check("rst_we", writeEnable, 0);    check("rst_nodesel", NodeSelect, 0);
    check("rst_writein", writeIn, 0);   check("rst_rowout", rowOut, 0);
    check("rst_rowidx", rowIndex, 0);   check("rst_rowvalid", rowValid, 0);
    check("rst_loaddone", loadDone, 0); check("rst_scandone", scanDone, 0);
    @(posedge clk); #1;

    // Full-rate load
    expect_writes(wa, NR);
    start(1'b1, 1'b0);
    load_words(wa, 1'b0);
    wait_load(0);
    check("load_latency", ld_cyc - t_start, 10);
    check("mem_row0", mem[0], 16'h2211);
    check("mem_row1", mem[1], 16'h4433);
    check("mem_row2", mem[2], 16'h6655);

    // Same load with wordValid toggling
    expect_writes(wa, NR);
    start(1'b1, 1'b0);
    load_words(wa, 1'b1);
    wait_load(1);
    check("toggle_mem_row2", mem[2], 16'h6655);

    // Back-to-back scan
    nv0 = nv_cnt;
    expect_scan();
    scan(0, h_out, h_idx);
    check("scan_latency", sd_cyc - t_start, 5);
    check("scan_valid_cycles", nv_cnt - nv0, 3);

    // Scan with a 4-cycle stall on row 1
    nv0 = nv_cnt;
    expect_scan();
    scan(4, h_out, h_idx);
    check("stall_hold_out", h_out, 16'h4433);
    check("stall_hold_idx", h_idx, 1);
    check("stall_scan_latency", sd_cyc - t_start, 9);
    check("stall_valid_cycles", nv_cnt - nv0, 7);

    // Simultaneous starts: load wins; scan during load ignored
    nv0 = nv_cnt;
    sd0 = sd_cnt;
    expect_writes(wb, NR);
    start(1'b1, 1'b1);
    check("both_start_busy", busy, 1);
    check("both_start_wordready", wordReady, 1);
    fork
      load_words(wb, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 scanStart = 1'b1;
        @(posedge clk);
        #1 scanStart = 1'b0;
      end
    join
    wait_load(2);
    repeat (3) @(posedge clk);
    #1;
    check("scan_dropped_busy", busy, 0);
    check("scan_dropped_valid", nv_cnt - nv0, 0);
    check("scan_dropped_done", sd_cnt, sd0);
    check("mem_row1_b", mem[1], 16'h7856);

    // Reset after the first word of row 1
    expect_writes(wc, 1);
    start(1'b1, 1'b0);
    load_words(wc, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);         check("mid_wordready", wordReady, 0);
    check("mid_we", writeEnable, 0);    check("mid_nodesel", NodeSelect, 0);
    check("mid_writein", writeIn, 0);   check("mid_rowout", rowOut, 0);
    check("mid_rowidx", rowIndex, 0);   check("mid_rowvalid", rowValid, 0);
    check("mid_loaddone", loadDone, 0); check("mid_scandone", scanDone, 0);
    check("mid_row1_kept", mem[1], 16'h7856);
    model_mem[1] = 16'h7856;
    @(posedge clk); #1;

    // Fresh load after reset, then scan it back
    expect_writes(wd, NR);
    start(1'b1, 1'b0);
    load_words(wd, 1'b0);
    wait_load(3);
    check("fresh_row0", mem[0], 16'hBBAA);
    expect_scan();
    scan(0, h_out, h_idx);

    check("writes_outstanding", wr_idx_q.size(), 0);
    check("rows_outstanding", rd_idx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
